// File: rtl/pc_pkg.sv
// Shared types and widths for the program-counter fetch controller.
package pc_pkg;

  localparam int LUT_IDX_W = 5;
  localparam int PC_W      = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } pc_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Decode/LUT/ROM-side bus of the fetch controller; BranchCnt appears only
// when PC_BRANCH_STATS_EN is defined.
interface pc_fetch_ctrl_if
  import pc_pkg::*;
#(
  parameter int D = PC_W
);

  logic                 start;
  logic                 stall;
  logic                 jump;
  logic [LUT_IDX_W-1:0] jump_idx;
  logic                 halt;
  logic [D-1:0]         lut_target;
  logic [LUT_IDX_W-1:0] lut_addr;
  logic [D-1:0]         prog_ctr;
  logic                 running;
  logic                 done;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0]          branch_cnt;

  modport master (
    output start, stall, jump, jump_idx, halt, lut_target,
    input  lut_addr, prog_ctr, running, done, branch_cnt
  );

  modport slave (
    input  start, stall, jump, jump_idx, halt, lut_target,
    output lut_addr, prog_ctr, running, done, branch_cnt
  );
`else
  modport master (
    output start, stall, jump, jump_idx, halt, lut_target,
    input  lut_addr, prog_ctr, running, done
  );

  modport slave (
    input  start, stall, jump, jump_idx, halt, lut_target,
    output lut_addr, prog_ctr, running, done
  );
`endif

endinterface

// File: rtl/pc_branch_counter.sv
// Saturating 16-bit taken-branch counter, used only under PC_BRANCH_STATS_EN.
module pc_branch_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] count
);

  // Clear wins over increment so a run always starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: steps or branches the PC via an external offset LUT
// and owns the Start/Done handshake. Optional branch statistics: PC_BRANCH_STATS_EN.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int           D        = PC_W,
  parameter logic [D-1:0] START_PC = '0,
  parameter logic [D-1:0] LAST_PC  = '1
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_ctrl_if.slave bus
);

  pc_state_t    state;
  logic [D-1:0] pc;
  logic         running;
  logic         done;

  // The LUT is combinational, so its index must be valid in the branch cycle itself.
  assign bus.lut_addr = ((state == RUN) && bus.jump) ? bus.jump_idx : '0;
  assign bus.prog_ctr = pc;
  assign bus.running  = running;
  assign bus.done     = done;

  // Priority in RUN is halt, stall, end-of-program, jump, step; reaching LAST_PC
  // ends the run instead of advancing past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= START_PC;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= RUN;
            pc      <= START_PC;
            running <= 1'b1;
            done    <= 1'b0;
          end
        end
        RUN: begin
          if (bus.halt || (!bus.stall && (pc == LAST_PC))) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (!bus.stall) begin
            if (bus.jump) begin
              pc <= pc + bus.lut_target;
            end else begin
              pc <= pc + D'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          pc      <= START_PC;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic start_load;
  logic jump_taken;

  // Only branches that actually move the PC count; stalls, halts and the final advance do not.
  assign start_load = (state != RUN) && bus.start;
  assign jump_taken = (state == RUN) && !bus.halt && !bus.stall && bus.jump && (pc != LAST_PC);

  pc_branch_counter u_branch_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (start_load),
    .inc   (jump_taken),
    .count (bus.branch_cnt)
  );
`endif

endmodule
